// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI responder
package spi_pkg;
    localparam int SYNC_STAGES = 2;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ = 8'h03;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WRITE,
        ST_READ,
        ST_IGNORE
    } resp_state_type;
    typedef enum logic {
        OP_WRITE,
        OP_READ
    } op_type;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with rise/fall pulses on the synchronized level
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] ff;
    logic prev;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ff <= {SYNC_STAGES{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            ff <= {ff[SYNC_STAGES-2:0], din};
            prev <= ff[SYNC_STAGES-1];
        end
    end
    assign rise = ff[SYNC_STAGES-1] & ~prev;
    assign fall = ~ff[SYNC_STAGES-1] & prev;
endmodule

// File: rtl/spi_responder.sv
// spi_responder: mode-0 SPI target with command/address decode over a byte register file
module spi_responder
    import spi_pkg::*;
#(
    parameter int DATA = 8,
    parameter int DEPTH = 32,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sclk,
    input  logic            cs_n,
    input  logic            mosi,
    output logic            miso,
    output logic            miso_oe,
    input  logic [AW-1:0]   host_addr,
    output logic [DATA-1:0] host_rdata,
    output logic            wr_strobe,
    output logic [AW-1:0]   wr_addr,
    output logic [DATA-1:0] wr_data,
    output logic            frame_err
);
    logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
    logic [SYNC_STAGES-1:0] mosi_ff;
    resp_state_type state, state_next;
    op_type op;
    logic [2:0] bit_cnt;
    logic [DATA-1:0] rx_sh, rx_byte, shift_out;
    logic [AW-1:0] addr, addr_inc;
    logic [DATA-1:0] regs [DEPTH];
    logic cnt_en, byte_done, cmd_ok, hold, wr_en, err_en, addr_load, rd_next, shift_en;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (.clk(clk), .rst(rst), .din(sclk), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync_edge #(.RST_VAL(1'b1)) u_cs (.clk(clk), .rst(rst), .din(cs_n), .rise(cs_rise), .fall(cs_fall));

    // mosi goes through the same number of stages as sclk so it is stable at the detected rise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) mosi_ff <= '0;
        else mosi_ff <= {mosi_ff[SYNC_STAGES-2:0], mosi};
    end
    assign mosi_s = mosi_ff[SYNC_STAGES-1];

    // a non-idle state means chip select is asserted as seen through the synchronizer
    assign cnt_en = sclk_rise && state != ST_IDLE;
    assign byte_done = cnt_en && bit_cnt == 3'd7;
    assign rx_byte = {rx_sh[DATA-2:0], mosi_s};
    assign cmd_ok = rx_byte == CMD_WRITE || rx_byte == CMD_READ;
    assign addr_inc = addr + AW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else state <= state_next;
    end

    always_comb begin
        state_next = cs_rise ? ST_IDLE :
                     cs_fall ? ST_CMD :
                     !byte_done ? state :
                     state == ST_CMD ? (cmd_ok ? ST_ADDR : ST_IGNORE) :
                     state == ST_ADDR ? (op == OP_READ ? ST_READ : ST_WRITE) :
                     state;
    end

    always_comb begin
        hold = !cs_rise && !cs_fall;
        wr_en = hold && byte_done && state == ST_WRITE;
        err_en = hold && byte_done && state == ST_CMD && !cmd_ok;
        addr_load = hold && byte_done && state == ST_ADDR;
        rd_next = hold && byte_done && state == ST_READ;
        shift_en = hold && sclk_fall && state == ST_READ;
        miso_oe = state == ST_READ;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= '0;
            rx_sh <= '0;
            op <= OP_WRITE;
            addr <= '0;
            shift_out <= '0;
            miso <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            frame_err <= 1'b0;
            host_rdata <= '0;
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            bit_cnt <= (cs_rise || cs_fall) ? 3'd0 : cnt_en ? bit_cnt + 3'd1 : bit_cnt;
            if (cnt_en) rx_sh <= rx_byte;
            if (hold && byte_done && state == ST_CMD) op <= rx_byte == CMD_READ ? OP_READ : OP_WRITE;
            if (addr_load) addr <= rx_byte[AW-1:0];
            else if (wr_en || rd_next) addr <= addr_inc;
            shift_out <= addr_load ? regs[rx_byte[AW-1:0]] :
                         rd_next ? regs[addr_inc] :
                         shift_en ? {shift_out[DATA-2:0], 1'b0} :
                         shift_out;
            miso <= state_next == ST_READ ? (shift_en ? shift_out[DATA-1] : miso) : 1'b0;
            wr_strobe <= wr_en;
            if (wr_en) begin
                wr_addr <= addr;
                wr_data <= rx_byte;
                regs[addr] <= rx_byte;
            end
            frame_err <= err_en;
            host_rdata <= regs[host_addr];
        end
    end
endmodule

// File: tb/tb_spi_responder.sv
// tb_spi_responder: directed SPI frames with hand-computed expectations for spi_responder
module tb_spi_responder;
    localparam int HP = 6;
    logic clk = 1'b0, rst, sclk, cs_n, mosi, miso, miso_oe, wr_strobe, frame_err;
    logic [4:0] host_addr, wr_addr;
    logic [7:0] host_rdata, wr_data;
    logic [7:0] rx_buf [4];
    logic [7:0] oe_buf [4];
    logic [4:0] stb_addr [$];
    logic [7:0] stb_data [$];
    logic [7:0] hr_at, hr_after, r, o, d;
    logic prev_stb = 1'b0;
    int err_cnt = 0;
    int n_checks = 0;
    int n_fail = 0;

    spi_responder dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .host_addr(host_addr), .host_rdata(host_rdata),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (prev_stb) hr_after = host_rdata;
        if (wr_strobe) begin
            stb_addr.push_back(wr_addr);
            stb_data.push_back(wr_data);
            hr_at = host_rdata;
        end
        if (frame_err) err_cnt++;
        prev_stb = wr_strobe;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx, output logic [7:0] oe);
        rx = '0;
        oe = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            repeat (HP) @(negedge clk);
            rx = {rx[6:0], miso};
            oe = {oe[6:0], miso_oe};
            sclk = 1'b1;
            repeat (HP) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [31:0] b, input int n);
        logic [7:0] fr, fo;
        cs_n = 1'b0;
        repeat (HP) @(negedge clk);
        for (int k = 0; k < n; k++) begin
            xfer(b[31-8*k -: 8], 8, fr, fo);
            rx_buf[k] = fr;
            oe_buf[k] = fo;
        end
        repeat (HP) @(negedge clk);
        cs_n = 1'b1;
        repeat (3 * HP) @(negedge clk);
    endtask

    task automatic host_rd(input logic [4:0] a, output logic [7:0] v);
        host_addr = a;
        @(negedge clk);
        v = host_rdata;
    endtask

    task automatic clear_log();
        stb_addr.delete();
        stb_data.delete();
    endtask

    initial begin
        rst = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; host_addr = '0;
        repeat (3) @(negedge clk);
        check("rst_miso", miso, 0);
        check("rst_oe", miso_oe, 0);
        check("rst_rdata", host_rdata, 0);
        check("rst_strobe", wr_strobe, 0);
        check("rst_wr", {wr_addr, wr_data}, 0);
        check("rst_err", frame_err, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        clear_log();
        frame(32'h0205A53C, 4);
        check("wr_cnt", stb_addr.size(), 2);
        if (stb_addr.size() == 2) begin
            check("wr0", {stb_addr[0], stb_data[0]}, {5'h05, 8'hA5});
            check("wr1", {stb_addr[1], stb_data[1]}, {5'h06, 8'h3C});
        end
        check("wr_last", {wr_addr, wr_data}, {5'h06, 8'h3C});
        host_rd(5'h06, d); check("host6", d, 8'h3C);
        host_rd(5'h05, d); check("host5", d, 8'hA5);

        clear_log();
        frame(32'h021F1122, 4);
        check("wrap_cnt", stb_addr.size(), 2);
        if (stb_addr.size() == 2) begin
            check("wrap0", {stb_addr[0], stb_data[0]}, {5'h1F, 8'h11});
            check("wrap1", {stb_addr[1], stb_data[1]}, {5'h00, 8'h22});
        end
        frame(32'h031F0000, 4);
        check("rd_byte0", rx_buf[2], 8'h11);
        check("rd_byte1", rx_buf[3], 8'h22);
        check("rd_hdr_miso", {rx_buf[0], rx_buf[1]}, 0);
        check("rd_oe", {oe_buf[0], oe_buf[1], oe_buf[2], oe_buf[3]}, 32'h0000FFFF);
        check("rd_end", {miso_oe, miso}, 0);

        clear_log();
        err_cnt = 0;
        frame(32'h7E010203, 4);
        check("bad_err", err_cnt, 1);
        check("bad_strobe", stb_addr.size(), 0);
        check("bad_oe", {oe_buf[0], oe_buf[1], oe_buf[2], oe_buf[3]}, 0);
        host_rd(5'h05, d); check("bad_r5", d, 8'hA5);
        host_rd(5'h1F, d); check("bad_r1f", d, 8'h11);
        host_rd(5'h01, d); check("bad_r1", d, 8'h00);

        clear_log();
        cs_n = 1'b0;
        repeat (HP) @(negedge clk);
        xfer(8'h02, 8, r, o);
        xfer(8'h04, 8, r, o);
        xfer(8'hFF, 5, r, o);
        repeat (HP) @(negedge clk);
        cs_n = 1'b1;
        repeat (3 * HP) @(negedge clk);
        check("part_strobe", stb_addr.size(), 0);
        host_rd(5'h04, d); check("part_r4", d, 8'h00);
        frame(32'h02049900, 3);
        check("part_next_cnt", stb_addr.size(), 1);
        host_rd(5'h04, d); check("part_next_r4", d, 8'h99);

        frame(32'h02085500, 3);
        host_addr = 5'h08;
        repeat (2) @(negedge clk);
        frame(32'h02087700, 3);
        check("same_old", hr_at, 8'h55);
        check("same_new", hr_after, 8'h77);

        cs_n = 1'b0;
        repeat (HP) @(negedge clk);
        xfer(8'h03, 8, r, o);
        xfer(8'h05, 8, r, o);
        xfer(8'h00, 4, r, o);
        check("mid_bits", r[3:0], 4'hA);
        check("mid_oe", miso_oe, 1);
        rst = 1'b0;
        #1;
        check("rst_mid", {miso, miso_oe, wr_strobe, frame_err}, 0);
        cs_n = 1'b1;
        sclk = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        host_rd(5'h05, d); check("rst_r5", d, 8'h00);
        host_rd(5'h08, d); check("rst_r8", d, 8'h00);
        host_rd(5'h1F, d); check("rst_r1f", d, 8'h00);

        clear_log();
        frame(32'h020AC300, 3);
        check("post_cnt", stb_addr.size(), 1);
        if (stb_addr.size() == 1) check("post_wr", {stb_addr[0], stb_data[0]}, {5'h0A, 8'hC3});
        frame(32'h030A0000, 3);
        check("post_rd", rx_buf[2], 8'hC3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
